// File: rtl/conv_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_sequencer
// Description : Tap/window sequencer for one strided KxK convolution layer,
//               with pipeline-aligned accumulator clear and sample strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_window_sequencer #(
    parameter int W_IN       = 258,
    parameter int WOUT       = 128,
    parameter int STRIDE     = 2,
    parameter int CHIN       = 3,
    parameter int KERNEL_DIM = 3,
    parameter int ADDR_W     = 18,
    parameter int WADDR_W    = 5,
    parameter int PIPE_LAT   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               stall_i,
    output logic [ADDR_W-1:0]  img_addr_o,
    output logic [WADDR_W-1:0] weight_addr_o,
    output logic               mac_en_o,
    output logic               clr_pulse_o,
    output logic               sample_o,
    output logic [7:0]         out_row_o,
    output logic [7:0]         out_col_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int TAPS = KERNEL_DIM * KERNEL_DIM * CHIN;
    localparam int KW   = (KERNEL_DIM > 1) ? $clog2(KERNEL_DIM) : 1;
    localparam int CW   = (CHIN > 1) ? $clog2(CHIN) : 1;
    localparam int DW   = $clog2(PIPE_LAT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [WADDR_W-1:0]  tap_q, tap_d;
    logic [KW-1:0]       kx_q, kx_d;
    logic [KW-1:0]       ky_q, ky_d;
    logic [CW-1:0]       ch_q, ch_d;
    logic [7:0]          row_q, row_d;
    logic [7:0]          col_q, col_d;
    logic [DW-1:0]       drain_q, drain_d;
    logic [PIPE_LAT-1:0] clr_pipe_q, clr_pipe_d;
    logic [7:0]          row_pipe_q [PIPE_LAT];
    logic [7:0]          row_pipe_d [PIPE_LAT];
    logic [7:0]          col_pipe_q [PIPE_LAT];
    logic [7:0]          col_pipe_d [PIPE_LAT];
    logic                sample_q, sample_d;
    logic [7:0]          out_row_q, out_row_d;
    logic [7:0]          out_col_q, out_col_d;

    logic issue;
    logic last_tap;
    logic last_win;
    logic clear_cnt;

    // Backpressure is only taken before the first tap so a window is never split.
    always_comb begin
        issue    = (state_q == S_RUN) && !(stall_i && (tap_q == '0));
        last_tap = issue && (tap_q == WADDR_W'(TAPS - 1));
        last_win = (row_q == 8'(WOUT - 1)) && (col_q == 8'(WOUT - 1));
    end

    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        kx_d      = kx_q;
        ky_d      = ky_q;
        ch_d      = ch_q;
        row_d     = row_q;
        col_d     = col_q;
        drain_d   = drain_q;
        clear_cnt = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d   = S_RUN;
                    clear_cnt = 1'b1;
                end
            end
            S_RUN: begin
                if (issue) begin
                    if (last_tap) begin
                        if (last_win) begin
                            state_d = S_DRAIN;
                            drain_d = '0;
                        end else begin
                            tap_d = '0;
                            kx_d  = '0;
                            ky_d  = '0;
                            ch_d  = '0;
                            if (col_q == 8'(WOUT - 1)) begin
                                col_d = '0;
                                row_d = row_q + 8'd1;
                            end else begin
                                col_d = col_q + 8'd1;
                            end
                        end
                    end else begin
                        tap_d = tap_q + WADDR_W'(1);
                        if (kx_q == KW'(KERNEL_DIM - 1)) begin
                            kx_d = '0;
                            if (ky_q == KW'(KERNEL_DIM - 1)) begin
                                ky_d = '0;
                                ch_d = ch_q + CW'(1);
                            end else begin
                                ky_d = ky_q + KW'(1);
                            end
                        end else begin
                            kx_d = kx_q + KW'(1);
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == DW'(PIPE_LAT)) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (clear_cnt) begin
            tap_d   = '0;
            kx_d    = '0;
            ky_d    = '0;
            ch_d    = '0;
            row_d   = '0;
            col_d   = '0;
            drain_d = '0;
        end
    end

    // Strobe and window-coordinate delay lines run freely, independent of stall.
    always_comb begin
        clr_pipe_d[0] = last_tap;
        row_pipe_d[0] = row_q;
        col_pipe_d[0] = col_q;
        for (int i = 1; i < PIPE_LAT; i++) begin
            clr_pipe_d[i] = clr_pipe_q[i-1];
            row_pipe_d[i] = row_pipe_q[i-1];
            col_pipe_d[i] = col_pipe_q[i-1];
        end
        sample_d  = clr_pipe_q[PIPE_LAT-1];
        out_row_d = row_pipe_q[PIPE_LAT-1];
        out_col_d = col_pipe_q[PIPE_LAT-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            tap_q      <= '0;
            kx_q       <= '0;
            ky_q       <= '0;
            ch_q       <= '0;
            row_q      <= '0;
            col_q      <= '0;
            drain_q    <= '0;
            clr_pipe_q <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                row_pipe_q[i] <= '0;
                col_pipe_q[i] <= '0;
            end
            sample_q   <= 1'b0;
            out_row_q  <= '0;
            out_col_q  <= '0;
        end else begin
            state_q    <= state_d;
            tap_q      <= tap_d;
            kx_q       <= kx_d;
            ky_q       <= ky_d;
            ch_q       <= ch_d;
            row_q      <= row_d;
            col_q      <= col_d;
            drain_q    <= drain_d;
            clr_pipe_q <= clr_pipe_d;
            for (int i = 0; i < PIPE_LAT; i++) begin
                row_pipe_q[i] <= row_pipe_d[i];
                col_pipe_q[i] <= col_pipe_d[i];
            end
            sample_q   <= sample_d;
            out_row_q  <= out_row_d;
            out_col_q  <= out_col_d;
        end
    end

    assign img_addr_o    = ADDR_W'(row_q) * ADDR_W'(STRIDE * W_IN)
                         + ADDR_W'(col_q) * ADDR_W'(STRIDE)
                         + ADDR_W'(ch_q)  * ADDR_W'(W_IN * W_IN)
                         + ADDR_W'(ky_q)  * ADDR_W'(W_IN)
                         + ADDR_W'(kx_q);
    assign weight_addr_o = tap_q;
    assign mac_en_o      = issue;
    assign clr_pulse_o   = clr_pipe_q[PIPE_LAT-1];
    assign sample_o      = sample_q;
    assign out_row_o     = out_row_q;
    assign out_col_o     = out_col_q;
    assign busy_o        = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done_o        = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_conv_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_window_sequencer
// Description : Scoreboard bench for conv_window_sequencer (default and a
//               reduced-size instance for whole-layer behaviour).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_conv_window_sequencer;

    localparam int W_IN = 258, WOUT = 128, STRIDE = 2, CHIN = 3, KD = 3;
    localparam int ADDR_W = 18, WADDR_W = 5, PIPE_LAT = 3;
    localparam int TAPS = KD * KD * CHIN;
    localparam int S_W_IN = 11, S_WOUT = 5, S_STRIDE = 2, S_CHIN = 2;
    localparam int S_ADDR_W = 10, S_PIPE_LAT = 2;
    localparam int S_TAPS = KD * KD * S_CHIN;

    typedef struct { int addr; int waddr; } tap_t;
    typedef struct { int row; int col; } win_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic               rst_n, start, stall;
    logic [ADDR_W-1:0]  img_addr;
    logic [WADDR_W-1:0] waddr;
    logic               mac_en, clr, sample, busy, done;
    logic [7:0]         orow, ocol;

    logic                 s_rst_n, s_start, s_stall;
    logic [S_ADDR_W-1:0]  s_img_addr;
    logic [WADDR_W-1:0]   s_waddr;
    logic                 s_mac_en, s_clr, s_sample, s_busy, s_done;
    logic [7:0]           s_orow, s_ocol;

    conv_window_sequencer u_dut (
        .clk(clk), .rst(rst_n), .start_i(start), .stall_i(stall),
        .img_addr_o(img_addr), .weight_addr_o(waddr), .mac_en_o(mac_en),
        .clr_pulse_o(clr), .sample_o(sample), .out_row_o(orow), .out_col_o(ocol),
        .busy_o(busy), .done_o(done)
    );

    conv_window_sequencer #(
        .W_IN(S_W_IN), .WOUT(S_WOUT), .STRIDE(S_STRIDE), .CHIN(S_CHIN),
        .KERNEL_DIM(KD), .ADDR_W(S_ADDR_W), .WADDR_W(WADDR_W), .PIPE_LAT(S_PIPE_LAT)
    ) u_small (
        .clk(clk), .rst(s_rst_n), .start_i(s_start), .stall_i(s_stall),
        .img_addr_o(s_img_addr), .weight_addr_o(s_waddr), .mac_en_o(s_mac_en),
        .clr_pulse_o(s_clr), .sample_o(s_sample), .out_row_o(s_orow), .out_col_o(s_ocol),
        .busy_o(s_busy), .done_o(s_done)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Reference: tap k of the layer in pixel coordinates of the padded map.
    function automatic tap_t model_tap(input int k, input int w_in, input int wout,
                                       input int stride, input int chin);
        tap_t r;
        int taps, win, t, row, col, c, ky, kx;
        taps = KD * KD * chin;
        win  = k / taps;
        t    = k % taps;
        row  = win / wout;
        col  = win % wout;
        c    = t / (KD * KD);
        ky   = (t / KD) % KD;
        kx   = t % KD;
        r.addr  = c * w_in * w_in + (row * stride + ky) * w_in + (col * stride + kx);
        r.waddr = t;
        return r;
    endfunction

    tap_t tap_q[$];
    win_t win_q[$];
    tap_t s_tap_q[$];

    task automatic push_main(input int nwin);
        win_t w;
        for (int k = 0; k < nwin * TAPS; k++)
            tap_q.push_back(model_tap(k, W_IN, WOUT, STRIDE, CHIN));
        for (int i = 0; i < nwin; i++) begin
            w.row = i / WOUT;
            w.col = i % WOUT;
            win_q.push_back(w);
        end
    endtask

    task automatic push_small(input int nwin);
        for (int k = 0; k < nwin * S_TAPS; k++)
            s_tap_q.push_back(model_tap(k, S_W_IN, S_WOUT, S_STRIDE, S_CHIN));
    endtask

    // Main-instance monitor
    logic prev_clr = 1'b0;
    always @(negedge clk) begin
        tap_t e;
        win_t w;
        if (mac_en) begin
            if (tap_q.size() == 0) check("tap_unexpected", 1, 0);
            else begin
                e = tap_q.pop_front();
                check("img_addr", int'(img_addr), e.addr);
                check("weight_addr", int'(waddr), e.waddr);
            end
        end
        if (sample) begin
            check("sample_follows_clr", int'(prev_clr), 1);
            if (win_q.size() == 0) check("sample_unexpected", 1, 0);
            else begin
                w = win_q.pop_front();
                check("out_row", int'(orow), w.row);
                check("out_col", int'(ocol), w.col);
            end
        end
        prev_clr = clr;
    end

    // Small-instance monitor
    int s_mac_cnt = 0, s_clr_cnt = 0, s_smp_cnt = 0, s_max = 0, s_last_base = -1;
    int s_last_tap_cyc = 0, s_last_row = -1, s_last_col = -1;
    always @(negedge clk) begin
        tap_t e;
        if (s_mac_en) begin
            s_mac_cnt++;
            if (int'(s_img_addr) > s_max) s_max = int'(s_img_addr);
            if (s_waddr == '0) s_last_base = int'(s_img_addr);
            if (int'(s_waddr) == S_TAPS - 1) s_last_tap_cyc = cyc;
            if (s_tap_q.size() == 0) check("s_tap_unexpected", 1, 0);
            else begin
                e = s_tap_q.pop_front();
                check("s_img_addr", int'(s_img_addr), e.addr);
                check("s_weight_addr", int'(s_waddr), e.waddr);
            end
        end
        if (s_clr) s_clr_cnt++;
        if (s_sample) begin
            s_smp_cnt++;
            s_last_row = int'(s_orow);
            s_last_col = int'(s_ocol);
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_mac_en"}, int'(mac_en), 0);
        check({tag, "_clr"}, int'(clr), 0);
        check({tag, "_sample"}, int'(sample), 0);
        check({tag, "_img_addr"}, int'(img_addr), 0);
        check({tag, "_weight_addr"}, int'(waddr), 0);
        check({tag, "_out_row"}, int'(orow), 0);
        check({tag, "_out_col"}, int'(ocol), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    task automatic wait_tap(input int v, input int limit);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (mac_en && int'(waddr) == v) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("wait_tap");
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic first_tap_zero(input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (mac_en) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout(name);
        else check(name, int'(img_addr), 0);
    endtask

    task automatic quiet_after_reset(input string name);
        int bad;
        bad = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (clr || sample || mac_en || busy) bad++;
        end
        check(name, bad, 0);
    endtask

    int ck_k [14]   = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 18, 27, 127*27, 128*27};
    int ck_adr [14] = '{0, 1, 2, 258, 259, 260, 516, 517, 518, 66564, 133128, 2, 254, 516};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, idle, fc, fs, f26, low, frz_bad, bad, done_cyc;
        bit ok;
        rst_n = 1'b0; start = 1'b0; stall = 1'b0;
        s_rst_n = 1'b0; s_start = 1'b0; s_stall = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", int'(busy), 0);

        // Phase 1: unstalled run through the first row boundary
        push_main(200);
        pulse_start();
        k = 0; idle = 0; fc = 0; fs = 0; f26 = 0;
        for (int n = 1; n <= 130 * TAPS + 5 && k < 130 * TAPS; n++) begin
            @(negedge clk);
            if (mac_en) begin
                for (int i = 0; i < 14; i++)
                    if (k == ck_k[i]) check("plan_addr", int'(img_addr), ck_adr[i]);
                if (f26 == 0 && int'(waddr) == TAPS - 1) f26 = n;
                k++;
            end else begin
                idle++;
            end
            if (clr && fc == 0) fc = n;
            if (sample && fs == 0) fs = n;
        end
        check("phase1_taps", k, 130 * TAPS);
        check("no_bubble", idle, 0);
        check("last_tap_cycle", f26, 27);
        check("clr_cycle", fc, 30);
        check("sample_cycle", fs, 31);

        // Stall held 5 cycles at the window (1,2) boundary
        @(posedge clk); #1 stall = 1'b1;
        low = 0; frz_bad = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (!mac_en) begin
                low++;
                if (int'(img_addr) != 520 || int'(waddr) != 0) frz_bad++;
            end
            if (n == 4) begin
                @(posedge clk); #1 stall = 1'b0;
            end
        end
        check("stall_low_cycles", low, 5);
        check("stall_frozen_addr", frz_bad, 0);

        // Stall inside a window is ignored
        wait_tap(9, 40);
        @(posedge clk); #1 stall = 1'b1;
        @(negedge clk);
        check("mid_stall_mac_en", int'(mac_en), 1);
        check("mid_stall_tap", int'(waddr), 10);
        @(posedge clk); #1 stall = 1'b0;

        // Random backpressure, checked by the scoreboard
        repeat (600) begin
            @(posedge clk); #1 stall = ($urandom_range(0, 3) == 0);
        end
        #0 stall = 1'b0;

        // Reset at t=13
        wait_tap(12, 100);
        @(posedge clk); #2 rst_n = 1'b0;
        #1 check_zero("rst_t13");
        tap_q.delete(); win_q.delete();
        quiet_after_reset("rst_t13_quiet");

        // Restart, then reset with a clear strobe in flight
        push_main(3);
        pulse_start();
        first_tap_zero("restart_addr");
        wait_tap(26, 60);
        @(posedge clk); #1;
        @(posedge clk); #2 rst_n = 1'b0;
        #1 check_zero("rst_pending");
        tap_q.delete(); win_q.delete();
        quiet_after_reset("rst_pending_quiet");

        push_main(3);
        pulse_start();
        first_tap_zero("restart2_addr");
        repeat (40) @(posedge clk);
        #1 rst_n = 1'b0;
        tap_q.delete(); win_q.delete();

        // Whole layer on the reduced instance
        push_small(S_WOUT * S_WOUT);
        @(posedge clk); #1 s_rst_n = 1'b1;
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        ok = 1'b0; done_cyc = 0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (s_done) begin
                ok = 1'b1;
                done_cyc = cyc;
                break;
            end
        end
        if (!ok) timeout("s_done");
        check("s_clr_count", s_clr_cnt, S_WOUT * S_WOUT);
        check("s_sample_count", s_smp_cnt, S_WOUT * S_WOUT);
        check("s_mac_count", s_mac_cnt, S_WOUT * S_WOUT * S_TAPS);
        check("s_max_addr", s_max, 241);
        check("s_last_base", s_last_base, 96);
        check("s_last_row", s_last_row, S_WOUT - 1);
        check("s_last_col", s_last_col, S_WOUT - 1);
        check("s_done_delay", done_cyc - s_last_tap_cyc, S_PIPE_LAT + 2);
        bad = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (!s_done || s_mac_en || s_busy || s_clr || s_sample) bad++;
        end
        check("s_done_hold", bad, 0);

        push_small(S_WOUT * S_WOUT);
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        @(negedge clk);
        check("s_restart_mac_en", int'(s_mac_en), 1);
        check("s_restart_addr", int'(s_img_addr), 0);
        check("s_restart_done", int'(s_done), 0);
        repeat (5) @(posedge clk);
        #1 s_rst_n = 1'b0;
        s_tap_q.delete();
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
